// File: rtl/mmix_mem_pkg.sv
// Shared types for the MMIX memory bridge: access size encoding, bridge FSM
// states and byte-enable constants for a big-endian view of 32-bit
// little-endian Avalon lanes (MMIX byte k of a tetra -> byteenable[3-k]).
package mmix_mem_pkg;

    typedef enum logic [1:0] {
        DS_BYTE  = 2'd0,
        DS_WYDE  = 2'd1,
        DS_TETRA = 2'd2,
        DS_OCTA  = 2'd3
    } datasize_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CMD0  = 3'd1,
        ST_WAIT0 = 3'd2,
        ST_CMD1  = 3'd3,
        ST_WAIT1 = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [3:0] BE_ALL     = 4'b1111;
    localparam logic [3:0] BE_WYDE_HI = 4'b1100;  // MMIX bytes 0,1 of the tetra
    localparam logic [3:0] BE_WYDE_LO = 4'b0011;  // MMIX bytes 2,3 of the tetra
    localparam logic [3:0] BE_BYTE_K0 = 4'b1000;  // MMIX byte 0; shift right by k

    localparam logic [1:0] BURST_SINGLE = 2'd1;
    localparam logic [1:0] BURST_OCTA   = 2'd2;

endpackage

// File: rtl/mmix_mem_bridge_if.sv
// Avalon-MM bus between the MMIX memory bridge (master) and the fabric (slave).
// Ports: address/byteenable/read/write/writedata driven by the master,
// readdata/waitrequest/readdatavalid driven by the slave.
// MMIX_MEM_BURST_EN adds avm_burstcount (master -> slave).
interface mmix_mem_bridge_if #(
    parameter int ADDR_W = 32
) ();
    logic [ADDR_W-1:0] avm_address;
    logic [3:0]        avm_byteenable;
    logic              avm_read;
    logic              avm_write;
    logic [31:0]       avm_writedata;
    logic [31:0]       avm_readdata;
    logic              avm_waitrequest;
    logic              avm_readdatavalid;
`ifdef MMIX_MEM_BURST_EN
    logic [1:0]        avm_burstcount;
`endif

    modport master (
`ifdef MMIX_MEM_BURST_EN
        output avm_burstcount,
`endif
        output avm_address,
        output avm_byteenable,
        output avm_read,
        output avm_write,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest,
        input  avm_readdatavalid
    );

    modport slave (
`ifdef MMIX_MEM_BURST_EN
        input  avm_burstcount,
`endif
        input  avm_address,
        input  avm_byteenable,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest,
        output avm_readdatavalid
    );
endinterface

// File: rtl/mmix_lane_steer.sv
// Lane steering between MMIX big-endian sizes and 32-bit Avalon byte lanes.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
// Ports: size/offset select lanes; beat1 picks the low tetra of an octa write;
// wdata -> replicated lane_wdata; rdata -> right-aligned, zero-extended rdata_ext.
module mmix_lane_steer
    import mmix_mem_pkg::*;
(
    input  datasize_e   size,
    input  logic [1:0]  offset,
    input  logic        beat1,
    input  logic [63:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] lane_wdata,
    output logic [31:0] rdata_ext
);

    always_comb begin
        be         = BE_ALL;
        lane_wdata = wdata[31:0];
        rdata_ext  = rdata;
        case (size)
            DS_BYTE: begin
                be         = BE_BYTE_K0 >> offset;
                lane_wdata = {4{wdata[7:0]}};
                // MMIX byte k sits in bits [31-8k -: 8]; {~k,3'b111} == 31-8k.
                rdata_ext  = {24'd0, rdata[{~offset, 3'b111} -: 8]};
            end
            DS_WYDE: begin
                be         = offset[1] ? BE_WYDE_LO : BE_WYDE_HI;
                lane_wdata = {2{wdata[15:0]}};
                rdata_ext  = {16'd0, (offset[1] ? rdata[15:0] : rdata[31:16])};
            end
            DS_TETRA: begin
                be         = BE_ALL;
                lane_wdata = wdata[31:0];
                rdata_ext  = rdata;
            end
            default: begin
                // Octa: high tetra travels first (big-endian).
                be         = BE_ALL;
                lane_wdata = beat1 ? wdata[31:0] : wdata[63:32];
                rdata_ext  = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mmix_mem_bridge.sv
// MMIX core memory port -> 32-bit Avalon-MM master bridge (octa split in two tetra beats).
// Latency: command 1 cycle after request; tetra write done at +2, tetra read +3, octa read +5 (+4 burst).
// Backpressure: avm_waitrequest stalls the FSM with all avm_* held; core holds request until mem_done.
// Ports: clk, reset_n (async, active-low); core side mem_address/mem_datasize/mem_read/
// mem_write/mem_writedata in, mem_readdata/mem_done out; Avalon side via mmix_mem_bridge_if.master.
// Option: MMIX_MEM_BURST_EN issues octa reads as one burstcount=2 command and drives avm_burstcount.
module mmix_mem_bridge
    import mmix_mem_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [63:0]       mem_address,
    input  logic [1:0]        mem_datasize,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [63:0]       mem_writedata,
    output logic [63:0]       mem_readdata,
    output logic              mem_done,
    mmix_mem_bridge_if.master avm
);

`ifdef MMIX_MEM_BURST_EN
    localparam bit BURST_EN = 1'b1;
    logic [1:0] burstcount_nxt;
`else
    localparam bit BURST_EN = 1'b0;
`endif

    state_e            state, state_nxt;

    // Request latched on leaving IDLE.
    logic              req_write;
    datasize_e         req_size;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic [31:0]       rd_hi;

    // Active request view: live inputs while in IDLE, latched copy otherwise,
    // so registered outputs for the first command can be computed one cycle early.
    logic              req_vld;
    logic              cur_write;
    logic              cur_octa;
    datasize_e         cur_size;
    logic [ADDR_W-1:0] cur_addr;
    logic [ADDR_W-1:0] aligned_addr;
    logic [63:0]       cur_wdata;

    logic              cmd_nxt;
    logic              beat1_nxt;
    logic [ADDR_W-1:0] address_nxt;
    logic [3:0]        be_nxt;
    logic [31:0]       writedata_nxt;
    logic              read_nxt;
    logic              write_nxt;
    logic              done_nxt;
    logic [63:0]       readdata_nxt;
    logic [31:0]       rd_hi_nxt;

    logic [3:0]        steer_be;
    logic [31:0]       steer_wdata;
    logic [31:0]       steer_rdata;

    logic              unused_addr_hi;
    assign unused_addr_hi = ^mem_address[63:ADDR_W];

    assign req_vld = mem_read | mem_write;

    // MMIX alignment: drop the low address bits below the access size.
    always_comb begin
        aligned_addr = mem_address[ADDR_W-1:0];
        case (datasize_e'(mem_datasize))
            DS_WYDE:  aligned_addr[0]   = 1'b0;
            DS_TETRA: aligned_addr[1:0] = 2'b00;
            DS_OCTA:  aligned_addr[2:0] = 3'b000;
            default:  ;
        endcase
    end

    always_comb begin
        if (state == ST_IDLE) begin
            cur_write = mem_write;  // write wins when both are asserted
            cur_size  = datasize_e'(mem_datasize);
            cur_addr  = aligned_addr;
            cur_wdata = mem_writedata;
        end else begin
            cur_write = req_write;
            cur_size  = req_size;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
        end
        cur_octa = (cur_size == DS_OCTA);
    end

    mmix_lane_steer u_steer (
        .size       (cur_size),
        .offset     (cur_addr[1:0]),
        .beat1      (beat1_nxt),
        .wdata      (cur_wdata),
        .rdata      (avm.avm_readdata),
        .be         (steer_be),
        .lane_wdata (steer_wdata),
        .rdata_ext  (steer_rdata)
    );

    // Next-state logic. readdatavalid only matters in the WAIT states.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req_vld) state_nxt = ST_CMD0;
            ST_CMD0: begin
                if (!avm.avm_waitrequest) begin
                    if (cur_write) state_nxt = cur_octa ? ST_CMD1 : ST_DONE;
                    else           state_nxt = ST_WAIT0;
                end
            end
            ST_WAIT0: begin
                if (avm.avm_readdatavalid) begin
                    if (!cur_octa)     state_nxt = ST_DONE;
                    else if (BURST_EN) state_nxt = ST_WAIT1;
                    else               state_nxt = ST_CMD1;
                end
            end
            ST_CMD1: begin
                if (!avm.avm_waitrequest) state_nxt = cur_write ? ST_DONE : ST_WAIT1;
            end
            ST_WAIT1: if (avm.avm_readdatavalid) state_nxt = ST_DONE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: values for the registered outputs, derived from the
    // state being entered so every output is a flop.
    always_comb begin
        cmd_nxt   = (state_nxt == ST_CMD0) || (state_nxt == ST_CMD1);
        beat1_nxt = (state_nxt == ST_CMD1);
        read_nxt  = cmd_nxt && !cur_write;
        write_nxt = cmd_nxt && cur_write;
        be_nxt    = cmd_nxt ? steer_be : 4'b0000;
        writedata_nxt = write_nxt ? steer_wdata : 32'd0;
        if (!cmd_nxt) begin
            address_nxt = '0;
        end else if (beat1_nxt && !BURST_EN) begin
            address_nxt = {cur_addr[ADDR_W-1:3], 3'b100};
        end else begin
            // A burst keeps the start address for both beats.
            address_nxt = {cur_addr[ADDR_W-1:2], 2'b00};
        end
`ifdef MMIX_MEM_BURST_EN
        burstcount_nxt = !cmd_nxt ? 2'd0 : (cur_octa ? BURST_OCTA : BURST_SINGLE);
`endif
        done_nxt = (state_nxt == ST_DONE);

        rd_hi_nxt    = rd_hi;
        readdata_nxt = mem_readdata;
        if (avm.avm_readdatavalid) begin
            if (state == ST_WAIT0) begin
                if (cur_octa) rd_hi_nxt    = avm.avm_readdata;
                else          readdata_nxt = {32'd0, steer_rdata};
            end else if (state == ST_WAIT1) begin
                readdata_nxt = {rd_hi, avm.avm_readdata};
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state              <= ST_IDLE;
            req_write          <= 1'b0;
            req_size           <= DS_BYTE;
            req_addr           <= '0;
            req_wdata          <= 64'd0;
            rd_hi              <= 32'd0;
            mem_readdata       <= 64'd0;
            mem_done           <= 1'b0;
            avm.avm_address    <= '0;
            avm.avm_byteenable <= 4'b0000;
            avm.avm_read       <= 1'b0;
            avm.avm_write      <= 1'b0;
            avm.avm_writedata  <= 32'd0;
`ifdef MMIX_MEM_BURST_EN
            avm.avm_burstcount <= 2'd0;
`endif
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && req_vld) begin
                req_write <= cur_write;
                req_size  <= cur_size;
                req_addr  <= cur_addr;
                req_wdata <= cur_wdata;
            end
            rd_hi              <= rd_hi_nxt;
            mem_readdata       <= readdata_nxt;
            mem_done           <= done_nxt;
            avm.avm_address    <= address_nxt;
            avm.avm_byteenable <= be_nxt;
            avm.avm_read       <= read_nxt;
            avm.avm_write      <= write_nxt;
            avm.avm_writedata  <= writedata_nxt;
`ifdef MMIX_MEM_BURST_EN
            avm.avm_burstcount <= burstcount_nxt;
`endif
        end
    end

endmodule

// File: doc/mmix_mem_bridge.md
# mmix_mem_bridge

Memory-side bridge directly downstream of the MMIX core's single memory port. It converts the core's 64-bit-address, size-tagged (byte/wyde/tetra/octa) big-endian requests into transfers on a 32-bit little-endian-lane Avalon-MM master for the DE0 system fabric. It returns right-aligned, zero-extended read data and a one-cycle `mem_done`. Octa accesses are split into two tetra beats.

## Interface
- `ADDR_W`, default 32: Avalon byte-address width.
- `clk` in 1: clock.
- `reset_n` in 1: reset, asynchronous, active-low.
- `mem_address` in 64: core byte address. Bit 63 is ignored and bits [62:ADDR_W] are ignored.
- `mem_datasize` in 2: 0 byte, 1 wyde, 2 tetra, 3 octa.
- `mem_read` in 1: read request. Held by the core until `mem_done`.
- `mem_write` in 1: write request. Held by the core until `mem_done`.
- `mem_writedata` in 64: store data, right-aligned.
- `mem_readdata` out 64: load data, right-aligned, zero-extended.
- `mem_done` out 1: one-cycle completion pulse.
- `avm_address` out ADDR_W: word-aligned byte address.
- `avm_byteenable` out 4: lane enables.
- `avm_read` out 1: Avalon read command.
- `avm_write` out 1: Avalon write command.
- `avm_writedata` out 32: write data.
- `avm_readdata` in 32: read data.
- `avm_waitrequest` in 1: slave stall.
- `avm_readdatavalid` in 1: read beat valid.
- `avm_burstcount` out 2: present only with `MMIX_MEM_BURST_EN`.

## Operation
- FSM states: IDLE, CMD0, WAIT0, CMD1, WAIT1, DONE.
- Requests are sampled only in IDLE.
  - If `mem_write` is asserted (including when `mem_read` is also asserted), the request is a write.
  - Otherwise, if `mem_read` is asserted, the request is a read.
  - The bridge latches address, size and write data at this point.
- Alignment follows MMIX rules: the address is forced down to a multiple of the access size before use.
- Byte lanes: MMIX byte offset k within a tetra maps to bits [31-8k -: 8] and to `avm_byteenable[3-k]`.
- Tetra/wyde/byte: one beat at `addr & ~3`.
  - Byteenable is 1111 for a tetra, 1100 or 0011 for a wyde (chosen by addr[1]), and one-hot for a byte.
  - Write data is replicated across all lanes.
- Octa: beat 0 is the high tetra at `addr & ~7`; beat 1 is the low tetra at +4.
  - Read result = {beat0, beat1}.
  - Writes send `mem_writedata[63:32]` first.
- Read extraction: selected lanes are shifted down to bit 0; upper bits are 0.
- CMD states drive `avm_read` or `avm_write`. All `avm_*` outputs hold stable while `avm_waitrequest` is 1.
- Write path: acceptance (waitrequest 0) ends the beat. The FSM goes to CMD1 for the second octa beat, otherwise to DONE.
- Read path: after acceptance the FSM goes to WAIT and captures data on `avm_readdatavalid`.
- DONE: `mem_done` is 1 for exactly one cycle, then the FSM returns to IDLE. `mem_readdata` holds its value until the next read completes.
- `avm_readdatavalid` in IDLE, DONE or CMD is ignored. This covers stray beats after reset.

## Timing
- Reset values: all `avm_*` outputs 0, `mem_readdata` 0, `mem_done` 0, state IDLE. All outputs are registered.
- Reset mid-transfer aborts immediately and asynchronously. No `mem_done` is generated.
- Request seen in IDLE at cycle 0 → command asserted from cycle 1.
- Tetra write with no wait states: `mem_done` at cycle 2.
- Tetra read with readdatavalid one cycle after acceptance (cycle 2): `mem_done` at cycle 3.
- Octa read: beat 1 is not issued before beat 0's data arrives. Done at cycle 5 under the same slave timing.
- Each cycle of `avm_waitrequest` adds one cycle of latency.
- The requester must drop or replace its request in the cycle after `mem_done`. The earliest re-sample is in IDLE, one cycle after DONE.

## Configuration
- `MMIX_MEM_BURST_EN` defined:
  - `avm_burstcount` port exists. It is 2 for octa and 1 otherwise.
  - Octa read is a single command accepting two readdatavalid beats (WAIT0→WAIT1 without CMD1). Octa read done at cycle 4.
  - Octa write asserts `avm_write` for two accepted beats with `avm_burstcount`=2 held throughout.
- Undefined: the port is absent and octa uses two independent single transfers.

## Structure
- Package `mmix_mem_pkg`: datasize enum (`DS_BYTE`/`DS_WYDE`/`DS_TETRA`/`DS_OCTA`), FSM state enum, byteenable lookup constants.
- One sub-module: `mmix_lane_steer`, combinational. It generates byteenable and replicated write data from size/offset, and extracts read data. It is instanced once.

## Test plan
- Tetra read at 0x8000_0000_0000_1004, readdata 0xDEADBEEF, readdatavalid latency 1 → `avm_address`=0x1004, be=1111, `mem_readdata`=0x00000000DEADBEEF, done at cycle 3.
- Byte read at 0x1006, readdata 0x11223344 → be=0010, `mem_readdata`=0x33. Wyde read at 0x1007 aligns to 0x1006 → be=0011, result 0x3344.
- Octa write at 0x200D, data 0x0123456789ABCDEF → beats at 0x2008 with 0x01234567, then 0x200C with 0x89ABCDEF. One done pulse.
- Wyde write at 0x3002, data 0xBEEF, waitrequest high for 3 cycles → signals stable while stalled, be=0011, writedata 0xBEEFBEEF, done 3 cycles later than the no-wait-state case.
- `mem_read` and `mem_write` both asserted → write executed. A stray `avm_readdatavalid` in IDLE does not change `mem_readdata`.
- `reset_n` pulsed low while in WAIT0 → outputs return to 0 asynchronously, no `mem_done`. The next request completes normally. With `MMIX_MEM_BURST_EN`, an octa read issues a single command with burstcount 2.
